// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_pkg
//  Purpose  : Shared constants for the SAP instruction-address path:
//             default address width, default return-stack depth and the
//             bit value driven onto the W-bus when the PC is not enabled.
//  Revision : 1.0  initial release
// ============================================================================
package sap_pkg;

    localparam int  AW_DEF         = 8;    // address width, matches the MAR
    localparam int  DEPTH_DEF      = 4;    // return-stack entries
    localparam logic C_BUS_ZERO_BIT = 1'b0; // idle W-bus bit value

endpackage : sap_pkg
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ret_stack
//  Purpose  : Hardware return-address stack (DEPTH x AW register file plus
//             stack pointer). No arbitration: the parent issues at most one
//             of push/pop per cycle and never pushes when full or pops when
//             empty.
//  Ports    : clk, clr   - clock and synchronous active-high reset
//             push, din  - store din at sp, then sp+1
//             pop        - sp-1
//             top        - entry at sp-1 (zero when empty)
//             empty/full - sp==0 / sp==DEPTH, combinational from sp
//  Revision : 1.0  initial release
// ============================================================================
module ret_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;

    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;

    // Write slot is the current sp; the top-of-stack slot is one below it.
    assign w_wr_idx = r_sp[IW-1:0];
    assign w_rd_idx = r_sp[IW-1:0] - IW'(1);

    assign empty = (r_sp == '0);
    assign full  = (r_sp == SPW'(DEPTH));
    // Reading an empty stack returns zero rather than a stale entry.
    assign top   = empty ? '0 : r_mem[w_rd_idx];

    // Stack pointer: only state that needs a reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sp <= '0;
        end else if (push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    // Entry storage: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : program_counter
//  Purpose  : SAP instruction address source. Holds the fetch address,
//             increments, loads jump targets and saves/restores return
//             addresses through ret_stack. Gated copy of pc drives the W-bus.
//  Ports    : clk, clr          - clock, synchronous active-high reset
//             cp, lp, call, ret - count / load / call / return requests
//             ep                - enable pc onto bus_out
//             addr_in           - jump or call target from the W-bus
//             pc                - registered current address
//             bus_out           - pc when ep, else zero (combinational)
//             stk_empty/full    - return-stack occupancy
//             stk_ovf/unf       - sticky call-while-full / ret-while-empty
//  Revision : 1.0  initial release
// ============================================================================
module program_counter
    import sap_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cp,
    input  logic          lp,
    input  logic          call,
    input  logic          ret,
    input  logic          ep,
    input  logic [AW-1:0] addr_in,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] bus_out,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          stk_ovf,
    output logic          stk_unf
);

    logic [AW-1:0] r_pc;
    logic          r_ovf;
    logic          r_unf;

    logic [AW-1:0] w_top;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Priority decode: clr > ret > call. The ~clr term keeps X on the
    // control inputs from reaching the stack while reset is asserted.
    assign w_pop  = ~clr & ret & ~w_empty;
    assign w_push = ~clr & ~ret & call & ~w_full;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_pc),      // pre-jump pc is already the return address
        .top   (w_top),
        .empty (w_empty),
        .full  (w_full)
    );

    // Exactly one action per cycle; lower-priority requests are dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (ret) begin
            if (w_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_pc <= w_top;
            end
        end else if (call) begin
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_pc <= addr_in;
            end
        end else if (lp) begin
            r_pc <= addr_in;
        end else if (cp) begin
            r_pc <= r_pc + AW'(1);  // wraps modulo 2^AW, no flag
        end
    end

    assign pc        = r_pc;
    assign bus_out   = ep ? r_pc : {AW{C_BUS_ZERO_BIT}};
    assign stk_empty = w_empty;
    assign stk_full  = w_full;
    assign stk_ovf   = r_ovf;
    assign stk_unf   = r_unf;

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_counter
//  Purpose  : Directed self-checking bench for program_counter: reset,
//             counting with wrap, bus gating, call/ret nesting, stack
//             overflow/underflow, simultaneous-request priority and
//             mid-sequence reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_program_counter;

    logic       clk = 1'b0;
    logic       clr, cp, lp, call, ret, ep;
    logic [7:0] addr_in;
    logic [7:0] pc, bus_out;
    logic       stk_empty, stk_full, stk_ovf, stk_unf;

    int n_cmp = 0;
    int n_err = 0;

    program_counter #(.AW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .cp        (cp),
        .lp        (lp),
        .call      (call),
        .ret       (ret),
        .ep        (ep),
        .addr_in   (addr_in),
        .pc        (pc),
        .bus_out   (bus_out),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    // Apply one set of controls for one clock edge, then release them and
    // settle 1 ns past the edge before the caller samples outputs.
    task automatic cyc(input logic c_clr, input logic c_ret, input logic c_call,
                       input logic c_lp, input logic c_cp, input logic [7:0] a);
        clr = c_clr; ret = c_ret; call = c_call; lp = c_lp; cp = c_cp; addr_in = a;
        @(posedge clk);
        #1;
        clr = 1'b0; ret = 1'b0; call = 1'b0; lp = 1'b0; cp = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 1, 1, 8'h5A);
        cyc(1, 1, 1, 1, 1, 8'h5A);
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", pc); end
        n_cmp++; if (stk_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", stk_empty); end
        n_cmp++; if (stk_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", stk_full); end
        n_cmp++; if ({stk_ovf, stk_unf} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b%b want 00", stk_ovf, stk_unf); end
        // X on controls while reset is held must not leak into state.
        cyc(1, 1'bx, 1'bx, 1'bx, 1'bx, 8'hxx);
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_x_pc: got %h want 00", pc); end
        n_cmp++; if (stk_empty !== 1'b1) begin n_err++; $display("FAIL rst_x_empty: got %b want 1", stk_empty); end
    endtask

    task automatic test_count();
        cyc(0, 0, 0, 1, 0, 8'hFE);
        n_cmp++; if (pc !== 8'hFE) begin n_err++; $display("FAIL cnt_load: got %h want FE", pc); end
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_cmp++; if (pc !== 8'hFF) begin n_err++; $display("FAIL cnt_ff: got %h want FF", pc); end
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL cnt_wrap: got %h want 00", pc); end
        n_cmp++; if ({stk_ovf, stk_unf} !== 2'b00) begin n_err++; $display("FAIL cnt_wrap_flags: got %b%b want 00", stk_ovf, stk_unf); end
        cyc(0, 0, 0, 0, 1, 8'h00);
        n_cmp++; if (pc !== 8'h01) begin n_err++; $display("FAIL cnt_01: got %h want 01", pc); end
        ep = 1'b0; #1;
        n_cmp++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL bus_off: got %h want 00", bus_out); end
        ep = 1'b1; #1;
        n_cmp++; if (bus_out !== 8'h01) begin n_err++; $display("FAIL bus_on: got %h want 01", bus_out); end
        ep = 1'b0;
        cyc(0, 0, 0, 0, 0, 8'h99);
        n_cmp++; if (pc !== 8'h01) begin n_err++; $display("FAIL hold: got %h want 01", pc); end
    endtask

    task automatic test_call_ret();
        cyc(0, 0, 0, 1, 0, 8'h10);
        cyc(0, 0, 1, 0, 0, 8'h40);
        n_cmp++; if (pc !== 8'h40) begin n_err++; $display("FAIL call1_pc: got %h want 40", pc); end
        n_cmp++; if (stk_empty !== 1'b0) begin n_err++; $display("FAIL call1_empty: got %b want 0", stk_empty); end
        cyc(0, 0, 1, 0, 0, 8'h80);
        n_cmp++; if (pc !== 8'h80) begin n_err++; $display("FAIL call2_pc: got %h want 80", pc); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h40) begin n_err++; $display("FAIL ret1_pc: got %h want 40", pc); end
        n_cmp++; if (stk_empty !== 1'b0) begin n_err++; $display("FAIL ret1_empty: got %b want 0", stk_empty); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h10) begin n_err++; $display("FAIL ret2_pc: got %h want 10", pc); end
        n_cmp++; if (stk_empty !== 1'b1) begin n_err++; $display("FAIL ret2_empty: got %b want 1", stk_empty); end
    endtask

    task automatic test_overflow_underflow();
        // pc=10, empty. Pushes 10,01,02,03 in order.
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 0, 0, 8'(i));
        n_cmp++; if (pc !== 8'h04) begin n_err++; $display("FAIL fill_pc: got %h want 04", pc); end
        n_cmp++; if (stk_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", stk_full); end
        n_cmp++; if (stk_ovf !== 1'b0) begin n_err++; $display("FAIL fill_ovf: got %b want 0", stk_ovf); end
        cyc(0, 0, 1, 0, 0, 8'hC0);
        n_cmp++; if (pc !== 8'h04) begin n_err++; $display("FAIL ovf_pc: got %h want 04", pc); end
        n_cmp++; if (stk_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", stk_ovf); end
        n_cmp++; if (stk_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", stk_full); end
        cyc(0, 0, 0, 0, 0, 8'h00);
        n_cmp++; if (stk_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", stk_ovf); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h03) begin n_err++; $display("FAIL pop1: got %h want 03", pc); end
        n_cmp++; if (stk_full !== 1'b0) begin n_err++; $display("FAIL pop1_full: got %b want 0", stk_full); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h02) begin n_err++; $display("FAIL pop2: got %h want 02", pc); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h01) begin n_err++; $display("FAIL pop3: got %h want 01", pc); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h10) begin n_err++; $display("FAIL pop4: got %h want 10", pc); end
        n_cmp++; if (stk_unf !== 1'b0) begin n_err++; $display("FAIL pop4_unf: got %b want 0", stk_unf); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h10) begin n_err++; $display("FAIL unf_pc: got %h want 10", pc); end
        n_cmp++; if (stk_unf !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", stk_unf); end
        n_cmp++; if (stk_ovf !== 1'b1) begin n_err++; $display("FAIL unf_ovf_kept: got %b want 1", stk_ovf); end
    endtask

    task automatic test_priority();
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h22);
        cyc(0, 0, 1, 0, 0, 8'h50);   // stack: 22
        cyc(0, 1, 1, 1, 1, 8'h77);   // ret wins
        n_cmp++; if (pc !== 8'h22) begin n_err++; $display("FAIL pri_ret_pc: got %h want 22", pc); end
        n_cmp++; if (stk_empty !== 1'b1) begin n_err++; $display("FAIL pri_ret_empty: got %b want 1", stk_empty); end
        cyc(0, 0, 1, 1, 0, 8'h33);   // call wins over lp, pushes 22
        n_cmp++; if (pc !== 8'h33) begin n_err++; $display("FAIL pri_call_pc: got %h want 33", pc); end
        n_cmp++; if (stk_empty !== 1'b0) begin n_err++; $display("FAIL pri_call_push: got %b want 0", stk_empty); end
        cyc(0, 0, 0, 1, 1, 8'h5A);   // lp wins over cp
        n_cmp++; if (pc !== 8'h5A) begin n_err++; $display("FAIL pri_lp_pc: got %h want 5A", pc); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (pc !== 8'h22) begin n_err++; $display("FAIL pri_ret_back: got %h want 22", pc); end
    endtask

    task automatic test_clr_midseq();
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 8'h11);
        cyc(0, 1, 0, 0, 0, 8'h00);   // underflow
        cyc(0, 0, 1, 0, 0, 8'hA1);
        cyc(0, 0, 1, 0, 0, 8'hA2);
        cyc(0, 0, 1, 0, 0, 8'hA3);
        cyc(0, 0, 1, 0, 0, 8'hA4);   // full
        cyc(0, 0, 1, 0, 0, 8'hB0);   // overflow
        cyc(0, 1, 0, 0, 0, 8'h00);   // 3 entries left
        n_cmp++; if (pc !== 8'hA3) begin n_err++; $display("FAIL mid_pc: got %h want A3", pc); end
        n_cmp++; if ({stk_ovf, stk_unf, stk_empty, stk_full} !== 4'b1100) begin n_err++; $display("FAIL mid_state: got %b%b%b%b want 1100", stk_ovf, stk_unf, stk_empty, stk_full); end
        cyc(1, 1, 0, 0, 1, 8'hEE);
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL clr_pc: got %h want 00", pc); end
        n_cmp++; if ({stk_ovf, stk_unf, stk_empty, stk_full} !== 4'b0010) begin n_err++; $display("FAIL clr_state: got %b%b%b%b want 0010", stk_ovf, stk_unf, stk_empty, stk_full); end
        cyc(0, 1, 0, 0, 0, 8'h00);
        n_cmp++; if (stk_unf !== 1'b1) begin n_err++; $display("FAIL clr_ret_unf: got %b want 1", stk_unf); end
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL clr_ret_pc: got %h want 00", pc); end
    endtask

    initial begin
        clr = 1'b1; cp = 1'b0; lp = 1'b0; call = 1'b0; ret = 1'b0; ep = 1'b0; addr_in = 8'h00;
        test_reset();
        test_count();
        test_call_ret();
        test_overflow_underflow();
        test_priority();
        test_clr_midseq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_program_counter
`default_nettype wire
